// File: rtl/intc_pkg.sv
// intc_pkg: shared types and constants for the interrupt controller.
//   state_t         : controller service state (IDLE, IRQ_SVC, NMI_SVC).
//   DEF_*           : default handler address constants.
//   INA_NMI/INA_IRQ : encoding of the INA vector-select output.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IRQ_SVC = 2'd1,
        NMI_SVC = 2'd2
    } state_t;

    localparam logic [31:0] DEF_IRQ_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEF_IRQ_STRIDE = 32'h0000_0010;
    localparam logic [31:0] DEF_NMI_VEC    = 32'h0000_0080;

    localparam logic INA_NMI = 1'b0;
    localparam logic INA_IRQ = 1'b1;

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational fixed-priority encoder.
//   elig  in  NUM_IRQ  eligible-source vector
//   found out 1        at least one bit of elig is set
//   idx   out 3        index of the lowest set bit (0 when found = 0)
module intc_prio_enc #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] elig,
    output logic               found,
    output logic [2:0]         idx
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches one NMI and NUM_IRQ maskable requests and
// answers the main controller's instruction-boundary poll.
//   Clk, Rst     clock (rising edge) and asynchronous active-high reset
//   irq_req      maskable requests, bit 0 highest priority
//   irq_mask     per-source enable (1 = enabled)
//   NMI          non-maskable request, rising-edge triggered
//   INTD         global maskable disable
//   poll, eret   boundary query and return-from-handler pulses
//   take, INA, irq_id, vector, epc_write   poll answer (combinational)
//   in_service   a handler is active
//   pending      latched maskable requests
//   state_dbg    current service state (intc_pkg::state_t encoding)
// Build option: define INTC_LEVEL_TRIG_EN to make maskable sources
// level-sensitive (pending follows irq_req, no latch, no clear on take).
//
// Handshake: poll is a one-cycle query with no ready side; take answers it
// in the same cycle. A take is committed on the clock edge that ends the
// poll cycle. eret in the same cycle as poll suppresses take.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] IRQ_BASE   = DEF_IRQ_BASE,
    parameter logic [31:0] IRQ_STRIDE = DEF_IRQ_STRIDE,
    parameter logic [31:0] NMI_VEC    = DEF_NMI_VEC
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               NMI,
    input  logic               INTD,
    input  logic               poll,
    input  logic               eret,
    output logic               take,
    output logic               INA,
    output logic [2:0]         irq_id,
    output logic [31:0]        vector,
    output logic               epc_write,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [1:0]         state_dbg
);

    state_t               state, state_nxt;
    logic                 nested, nested_nxt;
    logic                 nmi_q, nmi_pend;
    logic [NUM_IRQ-1:0]   pend_v;
    logic [NUM_IRQ-1:0]   elig;
    logic                 found;
    logic [2:0]           win_idx;
    logic                 nmi_elig;
    logic                 take_nmi, take_irq;

    // NMI edge latch; a new edge in the take cycle keeps the bit set.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            nmi_q    <= NMI;
            nmi_pend <= (nmi_pend & ~take_nmi) | (NMI & ~nmi_q);
        end
    end

`ifdef INTC_LEVEL_TRIG_EN
    // Level mode: the handler is responsible for dropping the request.
    assign pend_v = irq_req & {NUM_IRQ{~Rst}};
`else
    logic [NUM_IRQ-1:0] req_q, pend_q, clr_mask;

    assign clr_mask = take_irq ? (NUM_IRQ'(1) << win_idx) : '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            req_q  <= '0;
            pend_q <= '0;
        end else begin
            req_q  <= irq_req;
            // Set after clear: a fresh edge on the winner survives the take.
            pend_q <= (pend_q & ~clr_mask) | (irq_req & ~req_q);
        end
    end

    assign pend_v = pend_q;
`endif

    assign pending = pend_v;

    // Maskable sources only interrupt from IDLE; NMI can pre-empt IRQ_SVC.
    assign elig     = pend_v & irq_mask & {NUM_IRQ{~INTD && (state == IDLE)}};
    assign nmi_elig = nmi_pend && (state != NMI_SVC);

    intc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .elig  (elig),
        .found (found),
        .idx   (win_idx)
    );

    assign take      = poll & ~eret & (nmi_elig | found);
    assign take_nmi  = take & nmi_elig;
    assign take_irq  = take & ~nmi_elig;
    assign epc_write = take;

    always_comb begin
        INA    = INA_NMI;
        irq_id = 3'd0;
        vector = 32'd0;
        if (take_nmi) begin
            INA    = INA_NMI;
            vector = NMI_VEC;
        end else if (take_irq) begin
            INA    = INA_IRQ;
            irq_id = win_idx;
            vector = IRQ_BASE + 32'(win_idx) * IRQ_STRIDE;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            nested <= 1'b0;
        end else begin
            state  <= state_nxt;
            nested <= nested_nxt;
        end
    end

    // take is never high together with eret, so the branches are exclusive.
    always_comb begin
        state_nxt  = state;
        nested_nxt = nested;
        case (state)
            IDLE: begin
                if (take_nmi) begin
                    state_nxt  = NMI_SVC;
                    nested_nxt = 1'b0;
                end else if (take_irq) begin
                    state_nxt = IRQ_SVC;
                end
            end
            IRQ_SVC: begin
                if (eret) begin
                    state_nxt = IDLE;
                end else if (take_nmi) begin
                    state_nxt  = NMI_SVC;
                    nested_nxt = 1'b1;
                end
            end
            NMI_SVC: begin
                if (eret) begin
                    state_nxt  = nested ? IRQ_SVC : IDLE;
                    nested_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                nested_nxt = 1'b0;
            end
        endcase
    end

    assign in_service = (state != IDLE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed self-checking bench for
// interrupt_controller (default edge-latched build, NUM_IRQ = 4).
module tb_interrupt_controller;
    import intc_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  irq_req;
    logic [3:0]  irq_mask;
    logic        NMI;
    logic        INTD;
    logic        poll;
    logic        eret;
    logic        take;
    logic        INA;
    logic [2:0]  irq_id;
    logic [31:0] vector;
    logic        epc_write;
    logic        in_service;
    logic [3:0]  pending;
    logic [1:0]  state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    interrupt_controller #(.NUM_IRQ(4)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .irq_req    (irq_req),
        .irq_mask   (irq_mask),
        .NMI        (NMI),
        .INTD       (INTD),
        .poll       (poll),
        .eret       (eret),
        .take       (take),
        .INA        (INA),
        .irq_id     (irq_id),
        .vector     (vector),
        .epc_write  (epc_write),
        .in_service (in_service),
        .pending    (pending),
        .state_dbg  (state_dbg)
    );

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge; checks follow 1 unit
    // later, well clear of either clock edge.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_take(input string tag, input logic t, input logic ina,
                              input logic [2:0] id, input logic [31:0] vec);
        check({tag, ".take"}, 32'(take), 32'(t));
        check({tag, ".epc"}, 32'(epc_write), 32'(t));
        check({tag, ".ina"}, 32'(INA), 32'(ina));
        check({tag, ".id"}, 32'(irq_id), 32'(id));
        check({tag, ".vec"}, vector, vec);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        Rst = 1'b1; irq_req = '0; irq_mask = 4'hF; NMI = 1'b0;
        INTD = 1'b0; poll = 1'b0; eret = 1'b0;
        #3;
        check("rst.pend", 32'(pending), 32'h0);
        check("rst.insvc", 32'(in_service), 32'h0);
        check("rst.state", 32'(state_dbg), 32'(IDLE));
        check_take("rst", 1'b0, 1'b0, 3'd0, 32'h0);
        tick(); tick();
        Rst = 1'b0;
        tick();

        // 1: single source irq 2
        irq_req = 4'b0100;
        tick();
        irq_req = 4'b0000;
        check("t1.pend", 32'(pending), 32'h4);
        tick();
        poll = 1'b1; settle();
        check_take("t1", 1'b1, INA_IRQ, 3'd2, 32'h0000_0120);
        tick();
        poll = 1'b0;
        check("t1.pend_clr", 32'(pending), 32'h0);
        check("t1.insvc", 32'(in_service), 32'h1);
        check("t1.state", 32'(state_dbg), 32'(IRQ_SVC));
        eret = 1'b1; tick(); eret = 1'b0;
        check("t1.ret", 32'(state_dbg), 32'(IDLE));

        // 2: simultaneous irq 1 and 3, priority then second after eret
        irq_req = 4'b1010; tick(); irq_req = 4'b0000;
        check("t2.pend", 32'(pending), 32'hA);
        poll = 1'b1; settle();
        check_take("t2a", 1'b1, INA_IRQ, 3'd1, 32'h0000_0110);
        tick(); poll = 1'b0;
        check("t2.pend_left", 32'(pending), 32'h8);
        eret = 1'b1; tick(); eret = 1'b0;
        poll = 1'b1; settle();
        check_take("t2b", 1'b1, INA_IRQ, 3'd3, 32'h0000_0130);
        tick(); poll = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;

        // masked source stays pending and is not taken
        irq_mask = 4'b1110;
        irq_req = 4'b0001; tick(); irq_req = 4'b0000;
        poll = 1'b1; settle();
        check_take("mask", 1'b0, 1'b0, 3'd0, 32'h0);
        tick(); poll = 1'b0;
        check("mask.pend", 32'(pending), 32'h1);
        irq_mask = 4'hF;

        // 3: INTD blocks irq 0; NMI edge in the poll cycle is not taken yet
        INTD = 1'b1;
        poll = 1'b1; settle();
        check_take("t3.intd", 1'b0, 1'b0, 3'd0, 32'h0);
        NMI = 1'b1; settle();
        check_take("t3.nmi_same", 1'b0, 1'b0, 3'd0, 32'h0);
        tick();
        settle();
        check_take("t3.nmi", 1'b1, INA_NMI, 3'd0, 32'h0000_0080);
        tick(); poll = 1'b0; NMI = 1'b0;
        check("t3.state", 32'(state_dbg), 32'(NMI_SVC));
        eret = 1'b1; tick(); eret = 1'b0;
        check("t3.ret", 32'(state_dbg), 32'(IDLE));
        INTD = 1'b0;

        // 4: NMI nests over an irq handler
        poll = 1'b1; settle();
        check_take("t4.irq0", 1'b1, INA_IRQ, 3'd0, 32'h0000_0100);
        tick(); poll = 1'b0;
        NMI = 1'b1; tick(); NMI = 1'b0;
        poll = 1'b1; settle();
        check_take("t4.nmi", 1'b1, INA_NMI, 3'd0, 32'h0000_0080);
        tick(); poll = 1'b0;
        check("t4.state", 32'(state_dbg), 32'(NMI_SVC));
        eret = 1'b1; tick();
        check("t4.ret1", 32'(state_dbg), 32'(IRQ_SVC));
        tick(); eret = 1'b0;
        check("t4.ret2", 32'(state_dbg), 32'(IDLE));
        check("t4.insvc", 32'(in_service), 32'h0);

        // 5: eret with poll in IRQ_SVC suppresses take
        irq_req = 4'b0100; tick(); irq_req = 4'b0000;
        poll = 1'b1; tick(); poll = 1'b0;
        irq_req = 4'b0001; tick(); irq_req = 4'b0000;
        poll = 1'b1; settle();
        check_take("t5.busy", 1'b0, 1'b0, 3'd0, 32'h0);
        eret = 1'b1; settle();
        check_take("t5.eret", 1'b0, 1'b0, 3'd0, 32'h0);
        tick(); eret = 1'b0; poll = 1'b0;
        check("t5.state", 32'(state_dbg), 32'(IDLE));
        check("t5.pend", 32'(pending), 32'h1);
        // take irq 0 while a new edge on irq 0 arrives: set wins
        irq_req = 4'b0001; poll = 1'b1; settle();
        check_take("t5.take", 1'b1, INA_IRQ, 3'd0, 32'h0000_0100);
        tick(); poll = 1'b0; irq_req = 4'b0000;
        check("t5.setwins", 32'(pending), 32'h1);

        // 6: reset in NMI_SVC with pending 4'b0101
        irq_req = 4'b0100; tick(); irq_req = 4'b0000;
        NMI = 1'b1; tick(); NMI = 1'b0;
        poll = 1'b1; tick(); poll = 1'b0;
        check("t6.state", 32'(state_dbg), 32'(NMI_SVC));
        check("t6.pend", 32'(pending), 32'h5);
        Rst = 1'b1; poll = 1'b1; settle();
        check_take("t6.rst", 1'b0, 1'b0, 3'd0, 32'h0);
        check("t6.rst_pend", 32'(pending), 32'h0);
        check("t6.rst_state", 32'(state_dbg), 32'(IDLE));
        check("t6.rst_insvc", 32'(in_service), 32'h0);
        tick();
        Rst = 1'b0; settle();
        check_take("t6.after", 1'b0, 1'b0, 3'd0, 32'h0);
        tick(); poll = 1'b0;

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
